// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep sequencer for a double-SHA256 core: walks a nonce range, launches
// one hash per nonce and reports the first hash at or below the job target.
module nonce_sweep_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [607:0]     job_prefix,
    input  logic [31:0]      job_nonce_start,
    input  logic [31:0]      job_nonce_end,
    input  logic [255:0]     job_target,
    input  logic             abort,
    output logic             core_start,
    output logic [639:0]     core_header,
    input  logic [255:0]     core_hash,
    input  logic             core_done,
    output logic             busy,
    output logic             res_valid,
    output logic             res_found,
    output logic             res_exhausted,
    output logic             res_aborted,
    output logic             res_timeout,
    output logic [31:0]      res_nonce,
    output logic [255:0]     res_hash,
    output logic [CNT_W-1:0] hashes_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_r;
    logic [607:0]     prefix_r;
    logic [31:0]      nonce_r;
    logic [31:0]      nonce_end_r;
    logic [255:0]     target_r;
    logic [31:0]      wd_r;
    logic             res_valid_r;
    logic             res_found_r;
    logic             res_exhausted_r;
    logic             res_aborted_r;
    logic             res_timeout_r;
    logic [31:0]      res_nonce_r;
    logic [255:0]     res_hash_r;
    logic [CNT_W-1:0] hashes_done_r;

    logic wd_expired_s;
    logic hash_hit_s;

    // Watchdog expiry and target comparison against the latched hash
    always_comb begin
        wd_expired_s = 1'b0;
        hash_hit_s   = 1'b0;
        if (wd_r >= WD_LAST) begin
            wd_expired_s = 1'b1;
        end else begin
            wd_expired_s = 1'b0;
        end
        if (res_hash_r <= target_r) begin
            hash_hit_s = 1'b1;
        end else begin
            hash_hit_s = 1'b0;
        end
    end

    // Sequencer state, job registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_IDLE;
            prefix_r        <= 608'd0;
            nonce_r         <= 32'd0;
            nonce_end_r     <= 32'd0;
            target_r        <= 256'd0;
            wd_r            <= 32'd0;
            res_valid_r     <= 1'b0;
            res_found_r     <= 1'b0;
            res_exhausted_r <= 1'b0;
            res_aborted_r   <= 1'b0;
            res_timeout_r   <= 1'b0;
            res_nonce_r     <= 32'd0;
            res_hash_r      <= 256'd0;
            hashes_done_r   <= '0;
        end else begin
            res_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (job_valid) begin
                        prefix_r        <= job_prefix;
                        nonce_r         <= job_nonce_start;
                        nonce_end_r     <= job_nonce_end;
                        target_r        <= job_target;
                        hashes_done_r   <= '0;
                        res_found_r     <= 1'b0;
                        res_exhausted_r <= 1'b0;
                        res_aborted_r   <= 1'b0;
                        res_timeout_r   <= 1'b0;
                        res_nonce_r     <= 32'd0;
                        res_hash_r      <= 256'd0;
                        state_r         <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wd_r <= 32'd0;
                    if (abort) begin
                        res_aborted_r <= 1'b1;
                        res_valid_r   <= 1'b1;
                        state_r       <= S_IDLE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An abort racing a result wins and the result is dropped
                    if (abort) begin
                        if (core_done) begin
                            res_aborted_r <= 1'b1;
                            res_valid_r   <= 1'b1;
                            state_r       <= S_IDLE;
                        end else begin
                            wd_r    <= wd_r + 32'd1;
                            state_r <= S_DRAIN;
                        end
                    end else if (core_done) begin
                        res_hash_r    <= core_hash;
                        res_nonce_r   <= nonce_r;
                        hashes_done_r <= hashes_done_r + CNT_W'(1);
                        state_r       <= S_CHECK;
                    end else if (wd_expired_s) begin
                        res_timeout_r <= 1'b1;
                        res_valid_r   <= 1'b1;
                        state_r       <= S_IDLE;
                    end else begin
                        wd_r <= wd_r + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        res_aborted_r <= 1'b1;
                        res_valid_r   <= 1'b1;
                        state_r       <= S_IDLE;
                    end else if (hash_hit_s) begin
                        res_found_r <= 1'b1;
                        res_valid_r <= 1'b1;
                        state_r     <= S_IDLE;
                    end else if (nonce_r == nonce_end_r) begin
                        res_exhausted_r <= 1'b1;
                        res_valid_r     <= 1'b1;
                        state_r         <= S_IDLE;
                    end else begin
                        nonce_r <= nonce_r + 32'd1;
                        state_r <= S_LAUNCH;
                    end
                end
                S_DRAIN: begin
                    // Let the in-flight hash finish so the core is idle for the next job
                    if (core_done) begin
                        res_aborted_r <= 1'b1;
                        res_valid_r   <= 1'b1;
                        state_r       <= S_IDLE;
                    end else if (wd_expired_s) begin
                        res_aborted_r <= 1'b1;
                        res_timeout_r <= 1'b1;
                        res_valid_r   <= 1'b1;
                        state_r       <= S_IDLE;
                    end else begin
                        wd_r <= wd_r + 32'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign job_ready     = (state_r == S_IDLE);
    assign busy          = (state_r != S_IDLE);
    assign core_start    = (state_r == S_LAUNCH);
    assign core_header   = {prefix_r, nonce_r};
    assign res_valid     = res_valid_r;
    assign res_found     = res_found_r;
    assign res_exhausted = res_exhausted_r;
    assign res_aborted   = res_aborted_r;
    assign res_timeout   = res_timeout_r;
    assign res_nonce     = res_nonce_r;
    assign res_hash      = res_hash_r;
    assign hashes_done   = hashes_done_r;

endmodule
